pulse_monitor: RTL and testbench

Receiving-end checker for the single-cycle tick produced by `pulse_generator` in the Pong design. It measures the interval between ticks and counts them. It declares lock after a run of on-period intervals and raises sticky early/late errors when the tick stream drifts or stops. The block sits beside the timing chain (pixel/frame tick) for on-board debug and bench self-checking.

---
 rtl/pulse_monitor.sv | 134 +++++++++++++
 tb/tb_pulse_monitor.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_monitor.sv
// Tick-stream checker: measures the event interval, counts events,
// declares lock after a run of on-period intervals, flags early/late drift.
module pulse_monitor #(
  parameter int EXP_PERIOD = 4,
  parameter int TOL        = 0,
  parameter int LOCK_N     = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse,
  input  logic             clr_err,
  output logic             locked,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] pulse_count,
  output logic             err_early,
  output logic             err_late
);

  localparam int MW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0] LO   = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0] HI   = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAT  = '1;
  localparam logic [MW-1:0]    MLCK = MW'(LOCK_N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [MW-1:0]    match_q, match_d;
  logic [MW-1:0]    match_inc;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             early_q, early_d;
  logic             late_q, late_d;
  logic             set_early, set_late;
  logic             in_tol;

  assign in_tol    = (elapsed_q >= LO) && (elapsed_q <= HI);
  assign match_inc = match_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    match_d   = match_q;
    period_d  = period_q;
    count_d   = count_q;
    set_early = 1'b0;
    set_late  = 1'b0;

    if (pulse) begin
      count_d   = count_q + ONE;
      elapsed_d = ONE;
    end

    unique case (state_q)
      IDLE: begin
        if (pulse) begin
          state_d = ACQUIRE;
          match_d = '0;
        end else begin
          elapsed_d = '0;
        end
      end
      ACQUIRE, LOCKED: begin
        if (pulse) begin
          period_d = elapsed_q;
          if (state_q == ACQUIRE) begin
            if (in_tol) begin
              match_d = match_inc;
              if (match_inc >= MLCK)
                state_d = LOCKED;
            end else begin
              match_d = '0;
            end
          end else if (!in_tol) begin
            set_early = (elapsed_q < LO);
            state_d   = ACQUIRE;
            match_d   = '0;
          end
        end else if (elapsed_q == HI) begin
          // No event by the last in-tolerance edge: the stream has stopped
          set_late  = (state_q == LOCKED);
          state_d   = IDLE;
          match_d   = '0;
          elapsed_d = '0;
        end else if (elapsed_q != SAT) begin
          elapsed_d = elapsed_q + ONE;
        end
      end
      default: begin
        state_d   = IDLE;
        match_d   = '0;
        elapsed_d = '0;
      end
    endcase

    early_d = set_early | (early_q & ~clr_err);
    late_d  = set_late  | (late_q  & ~clr_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      elapsed_q <= '0;
      match_q   <= '0;
      period_q  <= '0;
      count_q   <= '0;
      early_q   <= 1'b0;
      late_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      match_q   <= match_d;
      period_q  <= period_d;
      count_q   <= count_d;
      early_q   <= early_d;
      late_q    <= late_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign period      = period_q;
  assign pulse_count = count_q;
  assign err_early   = early_q;
  assign err_late    = late_q;

endmodule

// File: tb/tb_pulse_monitor.sv
// Bench for pulse_monitor: directed scenarios plus a random tick stream
// checked against an event-time reference model.
module tb_pulse_monitor;

  localparam int E = 4;
  localparam int T = 0;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pulse = 1'b0;
  logic        clr_err = 1'b0;
  logic        locked;
  logic [15:0] period;
  logic [15:0] pulse_count;
  logic        err_early;
  logic        err_late;

  logic        reset2 = 1'b1;
  logic        pulse2 = 1'b0;
  logic        clr2 = 1'b0;
  logic        locked2;
  logic [3:0]  period2;
  logic [3:0]  count2;
  logic        early2;
  logic        late2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pulse_monitor dut (
    .clk(clk), .reset(reset), .pulse(pulse), .clr_err(clr_err),
    .locked(locked), .period(period), .pulse_count(pulse_count),
    .err_early(err_early), .err_late(err_late)
  );

  pulse_monitor #(.EXP_PERIOD(1), .TOL(0), .LOCK_N(4), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset2), .pulse(pulse2), .clr_err(clr2),
    .locked(locked2), .period(period2), .pulse_count(count2),
    .err_early(early2), .err_late(late2)
  );

  // Reference model: event times and a run length of good intervals
  int          cyc = 0;
  int          m_last = 0;
  int          m_run = 0;
  bit          m_active = 0;
  bit          m_locked = 0;
  bit          m_early = 0;
  bit          m_late = 0;
  logic [15:0] m_period = '0;
  logic [15:0] m_count = '0;

  task automatic model_clear();
    m_active = 0; m_locked = 0; m_run = 0;
    m_early = 0; m_late = 0;
    m_period = '0; m_count = '0;
  endtask

  task automatic step(input logic ev, input logic clr);
    int p;
    pulse = ev;
    clr_err = clr;
    @(posedge clk);
    cyc++;
    if (reset) begin
      model_clear();
    end else begin
      if (clr) begin
        m_early = 0;
        m_late = 0;
      end
      if (ev) begin
        m_count = m_count + 16'd1;
        if (!m_active) begin
          m_active = 1;
          m_run = 0;
        end else begin
          p = cyc - m_last;
          m_period = 16'(p);
          if (m_locked) begin
            if (p < E - T) begin
              m_early = 1;
              m_locked = 0;
              m_run = 0;
            end
          end else if (p >= E - T && p <= E + T) begin
            m_run++;
            if (m_run >= L) m_locked = 1;
          end else begin
            m_run = 0;
          end
        end
        m_last = cyc;
      end else if (m_active && (cyc - m_last) == E + T) begin
        if (m_locked) m_late = 1;
        m_active = 0;
        m_locked = 0;
        m_run = 0;
      end
    end
    #1;
    pulse = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic interval(input int gap, input logic clr_at_pulse);
    for (int j = 1; j < gap; j++) step(1'b0, 1'b0);
    step(1'b1, clr_at_pulse);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (locked !== 1'b0 || period !== 16'd0 || pulse_count !== 16'd0 ||
        err_early !== 1'b0 || err_late !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got l=%b p=%0d c=%0d e=%b t=%b want all 0",
               locked, period, pulse_count, err_early, err_late);
    end
    reset = 1'b0;
  endtask

  task automatic test_clean_lock();
    step(1'b1, 1'b0);
    for (int n = 2; n <= 5; n++) begin
      interval(4, 1'b0);
      if (n == 4) begin
        checks++;
        if (locked !== 1'b0) begin
          failures++;
          $display("FAIL lock_too_early: got locked=%b want 0", locked);
        end
      end
    end
    checks++;
    if (locked !== 1'b1 || period !== 16'd4 || pulse_count !== 16'd5 ||
        err_early !== 1'b0 || err_late !== 1'b0) begin
      failures++;
      $display("FAIL clean_lock: got l=%b p=%0d c=%0d e=%b t=%b want 1 4 5 0 0",
               locked, period, pulse_count, err_early, err_late);
    end
  endtask

  task automatic test_early();
    interval(3, 1'b0);
    checks++;
    if (err_early !== 1'b1 || locked !== 1'b0 || period !== 16'd3) begin
      failures++;
      $display("FAIL early_pulse: got e=%b l=%b p=%0d want 1 0 3",
               err_early, locked, period);
    end
    for (int n = 0; n < 4; n++) interval(4, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_early !== 1'b1 || pulse_count !== 16'd10) begin
      failures++;
      $display("FAIL early_relock: got l=%b e=%b c=%0d want 1 1 10",
               locked, err_early, pulse_count);
    end
  endtask

  task automatic test_stop();
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b0);
      checks++;
      if (locked !== 1'b1 || err_late !== 1'b0) begin
        failures++;
        $display("FAIL stop_premature k=%0d: got l=%b t=%b want 1 0",
                 k, locked, err_late);
      end
    end
    step(1'b0, 1'b0);
    checks++;
    if (locked !== 1'b0 || err_late !== 1'b1 ||
        pulse_count !== 16'd10 || period !== 16'd4) begin
      failures++;
      $display("FAIL stop_timeout: got l=%b t=%b c=%0d p=%0d want 0 1 10 4",
               locked, err_late, pulse_count, period);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (locked !== 1'b0 || pulse_count !== 16'd11 || period !== 16'd4) begin
      failures++;
      $display("FAIL stop_reenter: got l=%b c=%0d p=%0d want 0 11 4",
               locked, pulse_count, period);
    end
    for (int n = 0; n < 4; n++) interval(4, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_late !== 1'b1) begin
      failures++;
      $display("FAIL stop_relock: got l=%b t=%b want 1 1", locked, err_late);
    end
  endtask

  task automatic test_clear();
    step(1'b0, 1'b1);
    checks++;
    if (err_early !== 1'b0 || err_late !== 1'b0) begin
      failures++;
      $display("FAIL clear_alone: got e=%b t=%b want 0 0", err_early, err_late);
    end
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    checks++;
    if (err_early !== 1'b1 || err_late !== 1'b0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL clear_vs_set: got e=%b t=%b l=%b want 1 0 0",
               err_early, err_late, locked);
    end
  endtask

  task automatic test_async_reset();
    for (int n = 0; n < 4; n++) interval(4, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_lock: got locked=%b want 1", locked);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (locked !== 1'b0 || period !== 16'd0 || pulse_count !== 16'd0 ||
        err_early !== 1'b0 || err_late !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got l=%b p=%0d c=%0d e=%b t=%b want all 0",
               locked, period, pulse_count, err_early, err_late);
    end
    model_clear();
    step(1'b0, 1'b0);
    reset = 1'b0;
    step(1'b1, 1'b0);
    checks++;
    if (pulse_count !== 16'd1 || period !== 16'd0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_first: got c=%0d p=%0d l=%b want 1 0 0",
               pulse_count, period, locked);
    end
  endtask

  task automatic test_random();
    int gap;
    logic clr;
    for (int n = 0; n < 250; n++) begin
      gap = ($urandom_range(0, 9) < 6) ? E : int'($urandom_range(1, 7));
      for (int j = 1; j <= gap; j++) begin
        clr = ($urandom_range(0, 19) == 0);
        step(j == gap, clr);
        checks++;
        if (locked !== m_locked || period !== m_period ||
            pulse_count !== m_count || err_early !== m_early ||
            err_late !== m_late) begin
          failures++;
          $display("FAIL random cyc=%0d: got l=%b p=%0d c=%0d e=%b t=%b want %b %0d %0d %b %b",
                   cyc, locked, period, pulse_count, err_early, err_late,
                   m_locked, m_period, m_count, m_early, m_late);
        end
      end
    end
  endtask

  task automatic test_edge_width();
    reset2 = 1'b1;
    step(1'b0, 1'b0);
    reset2 = 1'b0;
    pulse2 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 1'b0);
      if (k == 2 || k == 9) begin
        checks++;
        if (period2 !== 4'd1) begin
          failures++;
          $display("FAIL w_period k=%0d: got %0d want 1", k, period2);
        end
      end
      if (k == 4 || k == 5 || k == 16) begin
        checks++;
        if (locked2 !== (k >= 5)) begin
          failures++;
          $display("FAIL w_lock k=%0d: got %b want %b", k, locked2, k >= 5);
        end
      end
      if (k == 15 || k == 16) begin
        checks++;
        if (count2 !== 4'(k)) begin
          failures++;
          $display("FAIL w_count k=%0d: got %0d want %0d", k, count2, 4'(k));
        end
      end
    end
    pulse2 = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_clean_lock();
    test_early();
    test_stop();
    test_clear();
    test_async_reset();
    test_random();
    test_edge_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
